pulse_stretcher: RTL and testbench
==================================

# pulse_stretcher

Output-side counterpart of the team's 4-stage input debouncer: turns a single-cycle internal event into a clean, debounce-safe level pulse on an output wire, for driving LEDs, buzzers, or another board's debounced input. The pulse is held high for a fixed number of cycles and followed by a mandatory low gap, so every downstream 4-stage debouncer sees one distinct high and one distinct low. Requests that arrive while a pulse is in progress are queued one deep; excess requests are flagged.

## Interface
- PULSE_LEN, 8: high time of output_wire in clk cycles; legal range 4..2^CNT_W.
- GAP_LEN, 4: forced low time after each pulse; legal range 1..2^CNT_W.
- CNT_W, 8: width of the internal down counter.

- clk  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- trigger  in  1  single-cycle pulse request, synchronous to clk.
- output_wire  out  1  stretched pulse, registered.
- busy  out  1  high while a pulse or gap is in progress, or a request is pending.
- dropped  out  1  one-cycle flag: a trigger was discarded.

## Operation
- FSM states: IDLE, HIGH, GAP. One pending flag. One down counter (CNT_W bits).
- IDLE: trigger -> HIGH, counter <= PULSE_LEN-1.
- HIGH: counter decrements each cycle. When counter==0 -> GAP, counter <= GAP_LEN-1.
- GAP: counter decrements each cycle. When counter==0:
  - pending set (or trigger in this same cycle) -> HIGH, counter <= PULSE_LEN-1, pending cleared.
  - otherwise -> IDLE.
- trigger in HIGH or GAP with pending clear -> pending set.
- trigger in HIGH or GAP with pending already set -> discarded; dropped=1 next cycle.
- A trigger in the last GAP cycle is consumed directly. It does not set pending and is never dropped, unless pending is already set. In that case pending is consumed and the trigger is dropped.
- output_wire = registered (state==HIGH). busy = (state!=IDLE) | pending.
- Reset values: state IDLE, counter 0, pending 0, output_wire 0, busy 0, dropped 0.
- Reset mid-pulse: output_wire falls asynchronously. The pending request is lost. There is no gap guarantee across reset.

## Timing
- Cycle n means the clock period following rising edge n. trigger high in cycle n is sampled at edge n+1.
- trigger in cycle n from IDLE -> output_wire high in cycles n+1..n+PULSE_LEN, low in n+PULSE_LEN+1..n+PULSE_LEN+GAP_LEN. busy falls in cycle n+PULSE_LEN+GAP_LEN+1 if nothing is pending.
- Latency from trigger to output_wire: 1 cycle. Minimum pulse period: PULSE_LEN+GAP_LEN cycles.
- dropped is high for exactly the cycle after the discarded trigger.
- trigger must be low for at least one cycle between requests; a held-high trigger counts as one request per cycle.

## Configuration
- PULSE_STRETCHER_RETRIGGER_EN defined:
  - trigger in HIGH reloads counter <= PULSE_LEN-1. The pulse is extended and pending is untouched.
  - GAP behaviour is unchanged.
- PULSE_STRETCHER_RETRIGGER_EN undefined: triggers in HIGH queue as described in Operation.

## Structure
- Shared package pulse_pkg: state enum (IDLE, HIGH, GAP), PULSE_LEN_MIN = 4 (the debouncer depth), GAP_LEN_MIN = 1.
- Parameter legality is checked by elaboration-time assertions against the pulse_pkg constants.
- One sub-module: pulse_down_counter, a loadable CNT_W-bit down counter with load, load value, enable, and a zero flag.

## Test plan
Parameters are PULSE_LEN=8, GAP_LEN=4 unless noted.
- Single trigger in cycle 10 -> output_wire high cycles 11–18, low 19–22; busy high 11–22, low from 23; dropped never high.
- Triggers in cycles 10 and 14, macro undefined -> pulses 11–18 and 23–30; output_wire low 19–22.
- Triggers in cycles 10, 12, 14 -> dropped high in cycle 15 only; exactly two pulses (11–18, 23–30).
- Macro defined, triggers in cycles 10 and 14 -> output_wire high continuously 11–22, low 23–26; single pulse.
- Trigger in cycle 10, reset_n low in cycle 13 -> output_wire, busy, dropped all 0 immediately. After release, a trigger in cycle 20 -> high 21–28.
- Trigger in cycle 10, second trigger in cycle 22 (last GAP cycle) -> pulses 11–18 and 23–30; dropped stays 0; no IDLE cycle between them.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared types and limits for the pulse stretcher.
// Minimum pulse length matches the 4-stage input debouncer depth.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int PULSE_LEN_MIN = 4;
    localparam int GAP_LEN_MIN   = 1;

endpackage

// File: rtl/pulse_down_counter.sv
// Loadable down counter with a zero flag.
// Load has priority over enable.
module pulse_down_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             enable,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into debounce-safe pulses with a low gap.
// PULSE_STRETCHER_RETRIGGER_EN: a trigger during HIGH extends the pulse.
module pulse_stretcher
    import pulse_pkg::*;
#(
    parameter int PULSE_LEN = 8,
    parameter int GAP_LEN   = 4,
    parameter int CNT_W     = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic trigger,
    output logic output_wire,
    output logic busy,
    output logic dropped
);

    if (PULSE_LEN < PULSE_LEN_MIN || PULSE_LEN > (1 << CNT_W)) begin : g_bad_pulse
        $error("pulse_stretcher: PULSE_LEN out of range");
    end
    if (GAP_LEN < GAP_LEN_MIN || GAP_LEN > (1 << CNT_W)) begin : g_bad_gap
        $error("pulse_stretcher: GAP_LEN out of range");
    end

    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_LEN - 1);

    state_t           state;
    state_t           state_next;
    logic             pending;
    logic             pending_next;
    logic             dropped_next;
    logic             load;
    logic [CNT_W-1:0] load_value;
    logic             enable;
    logic             zero;

    pulse_down_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (load),
        .load_value(load_value),
        .enable    (enable),
        .zero      (zero)
    );

    always_comb begin
        state_next   = state;
        pending_next = pending;
        dropped_next = 1'b0;
        load         = 1'b0;
        load_value   = PULSE_LOAD;
        enable       = 1'b0;
        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_next = HIGH;
                    load       = 1'b1;
                end
            end
            HIGH: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
                if (trigger) begin
                    load = 1'b1;
                end else if (zero) begin
                    state_next = GAP;
                    load       = 1'b1;
                    load_value = GAP_LOAD;
                end else begin
                    enable = 1'b1;
                end
`else
                if (trigger) begin
                    if (pending) dropped_next = 1'b1;
                    else         pending_next = 1'b1;
                end
                if (zero) begin
                    state_next = GAP;
                    load       = 1'b1;
                    load_value = GAP_LOAD;
                end else begin
                    enable = 1'b1;
                end
`endif
            end
            GAP: begin
                if (zero) begin
                    // last gap cycle: a pending request wins over a fresh one
                    if (pending) begin
                        state_next   = HIGH;
                        load         = 1'b1;
                        pending_next = 1'b0;
                        dropped_next = trigger;
                    end else if (trigger) begin
                        state_next = HIGH;
                        load       = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    enable = 1'b1;
                    if (trigger) begin
                        if (pending) dropped_next = 1'b1;
                        else         pending_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pending     <= 1'b0;
            dropped     <= 1'b0;
            output_wire <= 1'b0;
        end else begin
            state       <= state_next;
            pending     <= pending_next;
            dropped     <= dropped_next;
            output_wire <= (state_next == HIGH);
        end
    end

    assign busy = (state != IDLE) | pending;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher: cycle-by-cycle expected waveforms.
// Cycle c is the period after the c-th rising edge following reset release.
module tb_pulse_stretcher;

    localparam int PULSE_LEN = 8;
    localparam int GAP_LEN   = 4;
    localparam int CNT_W     = 8;
    localparam int NCYC      = 40;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic trigger = 1'b0;
    logic output_wire;
    logic busy;
    logic dropped;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = -1;

    bit trig_v   [NCYC];
    bit rst_v    [NCYC];
    bit exp_out  [NCYC];
    bit exp_busy [NCYC];
    bit exp_drop [NCYC];

    always #5 clk = ~clk;

    pulse_stretcher #(
        .PULSE_LEN(PULSE_LEN),
        .GAP_LEN  (GAP_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trigger    (trigger),
        .output_wire(output_wire),
        .busy       (busy),
        .dropped    (dropped)
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    task automatic clear_vec();
        for (int i = 0; i < NCYC; i++) begin
            trig_v[i]   = 1'b0;
            rst_v[i]    = 1'b0;
            exp_out[i]  = 1'b0;
            exp_busy[i] = 1'b0;
            exp_drop[i] = 1'b0;
        end
    endtask

    task automatic set_range(input int sel, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            case (sel)
                0: exp_out[i]  = 1'b1;
                1: exp_busy[i] = 1'b1;
                2: exp_drop[i] = 1'b1;
                default: rst_v[i] = 1'b1;
            endcase
        end
    endtask

    task automatic do_reset();
        trigger = 1'b0;
        reset_n = 1'b0;
        cyc     = -1;
        @(posedge clk);
        #1;
        check("rst/out", output_wire, 1'b0);
        check("rst/busy", busy, 1'b0);
        check("rst/drop", dropped, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run(input string name);
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            cyc     = c;
            trigger = trig_v[c];
            reset_n = !rst_v[c];
            @(negedge clk);
            check({name, "/out"}, output_wire, exp_out[c]);
            check({name, "/busy"}, busy, exp_busy[c]);
            check({name, "/drop"}, dropped, exp_drop[c]);
        end
        trigger = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        // single trigger
        do_reset();
        clear_vec();
        trig_v[10] = 1'b1;
        set_range(0, 11, 18);
        set_range(1, 11, 22);
        run("single");

        // second trigger during HIGH
        do_reset();
        clear_vec();
        trig_v[10] = 1'b1;
        trig_v[14] = 1'b1;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        set_range(0, 11, 22);
        set_range(1, 11, 26);
`else
        set_range(0, 11, 18);
        set_range(0, 23, 30);
        set_range(1, 11, 34);
`endif
        run("queue");

        // three triggers: third one overflows the queue
        do_reset();
        clear_vec();
        trig_v[10] = 1'b1;
        trig_v[12] = 1'b1;
        trig_v[14] = 1'b1;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        set_range(0, 11, 22);
        set_range(1, 11, 26);
`else
        set_range(0, 11, 18);
        set_range(0, 23, 30);
        set_range(1, 11, 34);
        set_range(2, 15, 15);
`endif
        run("drop");

        // asynchronous reset mid-pulse, then a fresh pulse
        do_reset();
        clear_vec();
        trig_v[10] = 1'b1;
        trig_v[20] = 1'b1;
        set_range(3, 13, 15);
        set_range(0, 11, 12);
        set_range(1, 11, 12);
        set_range(0, 21, 28);
        set_range(1, 21, 32);
        run("midrst");

        // trigger in the last gap cycle is consumed directly
        do_reset();
        clear_vec();
        trig_v[10] = 1'b1;
        trig_v[22] = 1'b1;
        set_range(0, 11, 18);
        set_range(0, 23, 30);
        set_range(1, 11, 34);
        run("lastgap");

        // last gap cycle with pending set: pending wins, trigger dropped
        do_reset();
        clear_vec();
        trig_v[10] = 1'b1;
        trig_v[12] = 1'b1;
        trig_v[22] = 1'b1;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        set_range(0, 11, 20);
        set_range(0, 25, 32);
        set_range(1, 11, 36);
`else
        set_range(0, 11, 18);
        set_range(0, 23, 30);
        set_range(1, 11, 34);
        set_range(2, 23, 23);
`endif
        run("pendgap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
